ring: RTL and testbench
=======================

RING -- requirements
Module: ring

Interface
REQ-001 Parameter: WIDTH, default 4, number of counter stages; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: out  output  WIDTH  counter state, driven directly from registers with no combinational path from inputs.
REQ-005 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL have no other ports: no enable, no load, no direction control.

Function
REQ-007 The block SHALL implement a WIDTH-bit Johnson (twisted-ring) counter.
REQ-008 Each rising clk with reset low and a legal state, out SHALL become {out[WIDTH-2:0], ~out[WIDTH-1]}.
REQ-009 For WIDTH=4, the legal sequence from 0000 SHALL be: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
REQ-010 The counter period SHALL be 2*WIDTH cycles (8 for WIDTH=4).
REQ-011 Wrap-around from 1000 to 0000 SHALL occur with no extra cycle or stall.
REQ-012 Legal states SHALL be exactly the 2*WIDTH thermometer patterns of the form 0..01..1 or 1..10..0, including all-zero and all-one.
REQ-013 Any other value of out SHALL be an illegal state.
REQ-014 If out holds an illegal state on a rising clk with reset low, out SHALL become all-zeros on that edge (self-correction within 1 cycle).
REQ-015 Legal-state detection SHALL be combinational on the current register value and SHALL be parameterised by WIDTH.
REQ-016 out SHALL change only on rising clk edges; there SHALL be no glitches or asynchronous paths.

Reset
REQ-017 When reset is high at a rising clk edge, out SHALL become all-zeros (0000 for WIDTH=4) on that edge, regardless of the current state.
REQ-018 While reset is held high, out SHALL remain all-zeros on every edge.
REQ-019 On the first rising edge with reset low after reset, out SHALL advance from all-zeros to 0..01.
REQ-020 Reset asserted mid-sequence SHALL take effect on the next rising edge and SHALL override counting and self-correction.
REQ-021 Before the first reset edge, out is undefined; the first reset edge SHALL fully initialise it.

Verification
REQ-022 Power-up: clk period 10 ns; hold reset=1 for one edge -> out=0000 after that edge, replacing X.
REQ-023 Release reset, then run 12 edges -> out=0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, 0011, 0111, 1111.
REQ-024 Reset mid-count: assert reset for one edge while out=0111 -> out=0000 on that edge, then 0001 on the next edge.
REQ-025 Held reset: keep reset=1 for 5 edges -> out stays 0000 on every edge.
REQ-026 Illegal recovery: force out=0101 via the bench, then release the force with reset low -> out=0000 after 1 edge, then the legal sequence resumes (0001 on the next edge).
REQ-027 WIDTH=5 build: after reset, run 10 edges -> 10 distinct legal states, then back to 00000.

Source files
------------

// File: rtl/ring.sv
// Johnson (twisted-ring) counter with one-cycle recovery from illegal states.
// The register drives out directly; illegal patterns are detected combinationally.
module ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_n;
    logic             low_fill;
    logic             high_fill;
    logic             legal;

    // 0..01..1 has no carry overlap with itself plus one; 1..10..0 is its complement.
    always_comb begin
        cnt_n     = ~cnt;
        low_fill  = ((cnt & (cnt + WIDTH'(1))) == '0);
        high_fill = ((cnt_n & (cnt_n + WIDTH'(1))) == '0);
        legal     = low_fill || high_fill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!legal) begin
            cnt <= '0;
        end else begin
            cnt <= {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
        end
    end

    assign out = cnt;

endmodule

// File: tb/tb_ring.sv
// Directed bench for ring: reset, full sequence, mid-count reset, held reset,
// illegal-state recovery, legal-state transitions and a WIDTH=5 instance.
module tb_ring;

    logic       clk;
    logic       reset;
    logic       reset5;
    logic [3:0] out;
    logic [4:0] out5;

    int checks;
    int failures;

    ring #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .out   (out)
    );

    ring #(.WIDTH(5)) dut5 (
        .clk   (clk),
        .reset (reset5),
        .out   (out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal WIDTH=4 sequence starting after 0000.
    logic [3:0] seq4 [8];
    logic [4:0] seq5 [10];

    initial begin
        seq4[0] = 4'b0001; seq4[1] = 4'b0011; seq4[2] = 4'b0111; seq4[3] = 4'b1111;
        seq4[4] = 4'b1110; seq4[5] = 4'b1100; seq4[6] = 4'b1000; seq4[7] = 4'b0000;
        seq5[0] = 5'b00001; seq5[1] = 5'b00011; seq5[2] = 5'b00111; seq5[3] = 5'b01111;
        seq5[4] = 5'b11111; seq5[5] = 5'b11110; seq5[6] = 5'b11100; seq5[7] = 5'b11000;
        seq5[8] = 5'b10000; seq5[9] = 5'b00000;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_init: got %b expected 0000", out);
        end
    endtask

    task automatic test_sequence();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (out !== seq4[i % 8]) begin
                failures++;
                $display("FAIL sequence[%0d]: got %b expected %b", i, out, seq4[i % 8]);
            end
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (out !== 4'b0111) begin
            failures++;
            $display("FAIL mid_reset_pre: got %b expected 0111", out);
        end
        reset = 1'b1;
        step();
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_hit: got %b expected 0000", out);
        end
        reset = 1'b0;
        step();
        checks++;
        if (out !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset_resume: got %b expected 0001", out);
        end
    endtask

    task automatic test_held_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out !== 4'b0000) begin
                failures++;
                $display("FAIL held_reset[%0d]: got %b expected 0000", i, out);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_illegal();
        logic [3:0] bad [4];
        logic [3:0] pat;
        bad[0] = 4'b0101; bad[1] = 4'b1010; bad[2] = 4'b0110; bad[3] = 4'b1001;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pat = bad[i];
            force dut.cnt = pat;
            #1;
            release dut.cnt;
            checks++;
            if (out !== pat) begin
                failures++;
                $display("FAIL illegal_load[%0d]: got %b expected %b", i, out, pat);
            end
            step();
            checks++;
            if (out !== 4'b0000) begin
                failures++;
                $display("FAIL illegal_clear[%0d]: got %b expected 0000", i, out);
            end
            step();
            checks++;
            if (out !== 4'b0001) begin
                failures++;
                $display("FAIL illegal_resume[%0d]: got %b expected 0001", i, out);
            end
        end
    endtask

    // Every legal state, planted directly, must advance to its successor.
    task automatic test_legal_transitions();
        logic [3:0] pat;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pat = seq4[(i + 7) % 8];
            force dut.cnt = pat;
            #1;
            release dut.cnt;
            step();
            checks++;
            if (out !== seq4[i]) begin
                failures++;
                $display("FAIL legal_next[%b]: got %b expected %b", pat, out, seq4[i]);
            end
        end
    endtask

    task automatic test_reset_overrides_illegal();
        logic [3:0] pat;
        pat = 4'b1011;
        reset = 1'b1;
        force dut.cnt = pat;
        #1;
        release dut.cnt;
        step();
        reset = 1'b0;
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_over_illegal: got %b expected 0000", out);
        end
        step();
        checks++;
        if (out !== 4'b0001) begin
            failures++;
            $display("FAIL reset_over_illegal_next: got %b expected 0001", out);
        end
    endtask

    task automatic test_width5();
        logic [4:0] seen [10];
        reset5 = 1'b1;
        step();
        checks++;
        if (out5 !== 5'b00000) begin
            failures++;
            $display("FAIL w5_reset: got %b expected 00000", out5);
        end
        reset5 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen[i] = out5;
            checks++;
            if (out5 !== seq5[i]) begin
                failures++;
                $display("FAIL w5_seq[%0d]: got %b expected %b", i, out5, seq5[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = i + 1; j < 10; j++) begin
                if (seen[i] === seen[j]) begin
                    checks++;
                    failures++;
                    $display("FAIL w5_distinct[%0d,%0d]: got %b twice expected distinct", i, j, seen[i]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        reset5   = 1'b1;
        test_reset();
        test_sequence();
        test_mid_reset();
        test_held_reset();
        test_illegal();
        test_legal_transitions();
        test_reset_overrides_illegal();
        test_width5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
